hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Consumes the D-stage Tuse/Tnew/destination fields produced by the main decoder.
- Tracks in-flight writers through E/M/W shadow registers and decides stall, bubble and forward selects.
- Adds a parametrised multiply/divide (HI/LO) busy tracker that stalls D-stage HI/LO users.

Parameters:
- AW, 5, register-address width; register 0 is hardwired zero.
- TW, 2, Tuse/Tnew field width.
- MULT_LAT, 5, cycles HI/LO stays busy after a mult enters E; must be >=1.
- DIV_LAT, 10, cycles HI/LO stays busy after a div enters E; must be >=1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d_rs  in  AW  D-stage rs address.
- d_rt  in  AW  D-stage rt address.
- d_tuse_rs  in  TW  cycles until rs is needed.
- d_tuse_rt  in  TW  cycles until rt is needed.
- d_dst  in  AW  D-stage destination register.
- d_regwrite  in  1  D-stage instruction writes d_dst.
- d_tnew  in  TW  D-stage Tnew.
- d_md_start  in  1  D-stage instruction is mult/multu/div/divu.
- d_md_is_div  in  1  selects DIV_LAT when d_md_start=1.
- d_md_use  in  1  D-stage instruction reads or writes HI/LO; asserted for every md_start instruction.
- stall  out  1  freeze PC and the D register.
- e_bubble  out  1  clear the E pipeline register this edge; equals stall.
- fwd_rs  out  2  0=regfile, 1=E, 2=M, 3=W.
- fwd_rt  out  2  same encoding as fwd_rs.
- md_busy  out  1  HI/LO counter nonzero.

Behaviour:
Reset (async, rst_n=0):
- All stage registers cleared: dst=0, regwrite=0, tnew=0.
- md counter=0.
- Outputs then follow the combinational rules below; with cleared state, stall=0 and fwd=0.

Stage advance, every rising edge:
- W <= M with tnew sat-decremented.
- M <= E with tnew sat-decremented.
- E <= D with d_tnew sat-decremented, if stall=0; otherwise E <= bubble (dst=0, regwrite=0, tnew=0).
- Saturating decrement: 0 stays 0.

Match definition:
- A stage matches a source address a when a!=0, stage.regwrite=1 and stage.dst=a.
- Only the nearest matching stage is considered, priority E > M > W.
- Address 0 never matches, stalls or forwards.

Data stall:
- stall_rs = nearest match for d_rs has stage.tnew > d_tuse_rs; stall_rt is analogous.

HI/LO stall:
- stall_md = d_md_use && md_busy.
- stall = stall_rs | stall_rt | stall_md, purely combinational from current registers and D inputs.

Forwarding:
- fwd_rs = code of the nearest matching stage if that stage's tnew==0; otherwise 0.
- If the nearest match has tnew != 0, fwd_rs=0 and stall is asserted; the outer pipeline ignores fwd in that case.

md counter:
- Width = clog2(max(MULT_LAT,DIV_LAT)+1).
- If d_md_start=1 and stall=0 at an edge: load DIV_LAT if d_md_is_div=1, else MULT_LAT.
- Else if counter != 0: decrement.
- md_busy = counter != 0, so it asserts the cycle the instruction sits in E.
- A start cannot arrive while busy, because it stalls via d_md_use.
- If d_md_start arrives with stall=1 from a data hazard, no load occurs; it loads on the accepting edge.

Simultaneous events:
- rs and rt are evaluated independently, and either may stall.
- The md stall and data stalls are ORed.
- The counter reaching 0 releases the stall in the same cycle that md_busy drops.

Reset mid-operation:
- All in-flight tracking and the md count are discarded immediately.
- There is no recovery state.

Test Plan:
1. lw $8 (d_tnew=3) then add using rs=$8 (tuse=1) -> cycle 1: E.tnew=2>1, stall=1, e_bubble=1; cycle 2: M.tnew=1, stall=0, fwd_rs=0; cycle 3: W.tnew=0, fwd_rs=3.
2. ori $9 (tnew=2) then beq with rs=$9, rt=$9 (tuse=0) -> stall=1 for 1 cycle (E.tnew=1), then fwd_rs=fwd_rt=2 (M.tnew=0).
3. add $10 in E and lw $10 in M, then D reads $10 with tuse=1 -> nearest is E (tnew=1, not >1), fwd_rs=0, no stall; next cycle the same reader sees M (tnew=0), fwd_rs=2.
4. Writer with dst=0 and regwrite=1, then reader of $0 -> stall=0, fwd=0 throughout.
5. div accepted (DIV_LAT=10), then mfhi in D the next cycle -> md_busy=1 and stall=1 for 10 cycles, released when the counter hits 0; repeat with mult -> 5 cycles.
6. rst_n pulsed low while md count=7 and E holds lw $8 -> immediately md_busy=0, stall=0, fwd=0; the first post-reset reader of $8 forwards 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query bundle: decoder fields in, stall/forward decisions out.
// The master drives the D-stage fields; the scoreboard is the slave.
interface hazard_scoreboard_if #(
   parameter int unsigned AW = 5,
   parameter int unsigned TW = 2
);
   logic [AW-1:0] d_rs;
   logic [AW-1:0] d_rt;
   logic [TW-1:0] d_tuse_rs;
   logic [TW-1:0] d_tuse_rt;
   logic [AW-1:0] d_dst;
   logic          d_regwrite;
   logic [TW-1:0] d_tnew;
   logic          d_md_start;
   logic          d_md_is_div;
   logic          d_md_use;
   logic          stall;
   logic          e_bubble;
   logic [1:0]    fwd_rs;
   logic [1:0]    fwd_rt;
   logic          md_busy;

   modport master (
      output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_regwrite, d_tnew,
             d_md_start, d_md_is_div, d_md_use,
      input  stall, e_bubble, fwd_rs, fwd_rt, md_busy
   );

   modport slave (
      input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_regwrite, d_tnew,
             d_md_start, d_md_is_div, d_md_use,
      output stall, e_bubble, fwd_rs, fwd_rt, md_busy
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard controller for a 5-stage MIPS pipeline with E/M/W writer
// shadows, nearest-stage forwarding and a HI/LO multiply/divide busy counter.
module hazard_scoreboard #(
   parameter int unsigned AW       = 5,
   parameter int unsigned TW       = 2,
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input logic                clk,
   input logic                rst_n,
   hazard_scoreboard_if.slave bus
);

   localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CW      = $clog2(MAX_LAT + 1);

   typedef struct packed {
      logic [AW-1:0] dst;
      logic          rw;
      logic [TW-1:0] tnew;
   } stage_t;

   typedef struct packed {
      logic          hit;
      logic [1:0]    code;
      logic [TW-1:0] tnew;
   } lookup_t;

   function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
      return (t == '0) ? '0 : t - TW'(1);
   endfunction

   function automatic stage_t advance(input stage_t s);
      stage_t n;
      n      = s;
      n.tnew = sat_dec(s.tnew);
      return n;
   endfunction

   // Nearest writer wins: E shadows M, which shadows W. $0 never matches.
   function automatic lookup_t lookup(input logic [AW-1:0] a, input stage_t e,
                                      input stage_t m, input stage_t w);
      lookup_t h;
      h = '0;
      if (a != '0) begin
         if (e.rw && e.dst == a) begin
            h = '{hit: 1'b1, code: 2'd1, tnew: e.tnew};
         end else if (m.rw && m.dst == a) begin
            h = '{hit: 1'b1, code: 2'd2, tnew: m.tnew};
         end else if (w.rw && w.dst == a) begin
            h = '{hit: 1'b1, code: 2'd3, tnew: w.tnew};
         end
      end
      return h;
   endfunction

   stage_t         r_e, r_m, r_w;
   logic [CW-1:0]  r_md_cnt;

   stage_t         w_d_stage;
   lookup_t        w_rs, w_rt;
   logic           w_stall_rs, w_stall_rt, w_stall_md, w_stall, w_md_busy;
   logic [1:0]     w_fwd_rs, w_fwd_rt;

   always_comb begin
      w_d_stage  = '{dst: bus.d_dst, rw: bus.d_regwrite, tnew: sat_dec(bus.d_tnew)};
      w_rs       = lookup(bus.d_rs, r_e, r_m, r_w);
      w_rt       = lookup(bus.d_rt, r_e, r_m, r_w);
      w_stall_rs = w_rs.hit && (w_rs.tnew > bus.d_tuse_rs);
      w_stall_rt = w_rt.hit && (w_rt.tnew > bus.d_tuse_rt);
      w_fwd_rs   = (w_rs.hit && w_rs.tnew == '0) ? w_rs.code : 2'd0;
      w_fwd_rt   = (w_rt.hit && w_rt.tnew == '0) ? w_rt.code : 2'd0;
      w_md_busy  = (r_md_cnt != '0);
      w_stall_md = bus.d_md_use && w_md_busy;
      w_stall    = w_stall_rs || w_stall_rt || w_stall_md;
   end

   assign bus.stall    = w_stall;
   assign bus.e_bubble = w_stall;
   assign bus.fwd_rs   = w_fwd_rs;
   assign bus.fwd_rt   = w_fwd_rt;
   assign bus.md_busy  = w_md_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_e      <= '0;
         r_m      <= '0;
         r_w      <= '0;
         r_md_cnt <= '0;
      end else begin
         r_w <= advance(r_m);
         r_m <= advance(r_e);
         r_e <= w_stall ? stage_t'('0) : w_d_stage;
         // A start held back by a data stall loads only on its accepting edge.
         if (bus.d_md_start && !w_stall) begin
            r_md_cnt <= bus.d_md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
         end else if (w_md_busy) begin
            r_md_cnt <= r_md_cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stall, forwarding, HI/LO busy and
// asynchronous reset scenarios with hand-computed expectations.
module tb_hazard_scoreboard;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_fail;

   hazard_scoreboard_if #(.AW(5), .TW(2)) bus ();

   hazard_scoreboard #(
      .AW       (5),
      .TW       (2),
      .MULT_LAT (5),
      .DIV_LAT  (10)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic st, input logic [1:0] frs,
                       input logic [1:0] frt, input logic busy);
      chk($sformatf("%s.stall", tag), 8'(bus.stall), 8'(st));
      chk($sformatf("%s.e_bubble", tag), 8'(bus.e_bubble), 8'(st));
      chk($sformatf("%s.fwd_rs", tag), 8'(bus.fwd_rs), 8'(frs));
      chk($sformatf("%s.fwd_rt", tag), 8'(bus.fwd_rt), 8'(frt));
      chk($sformatf("%s.md_busy", tag), 8'(bus.md_busy), 8'(busy));
   endtask

   task automatic idle_d();
      bus.d_rs        = '0;
      bus.d_rt        = '0;
      bus.d_tuse_rs   = '0;
      bus.d_tuse_rt   = '0;
      bus.d_dst       = '0;
      bus.d_regwrite  = 1'b0;
      bus.d_tnew      = '0;
      bus.d_md_start  = 1'b0;
      bus.d_md_is_div = 1'b0;
      bus.d_md_use    = 1'b0;
   endtask

   task automatic wr(input logic [4:0] dst, input logic [1:0] tnew);
      bus.d_dst      = dst;
      bus.d_regwrite = 1'b1;
      bus.d_tnew     = tnew;
   endtask

   task automatic rd(input logic [4:0] rs, input logic [1:0] tu_rs,
                     input logic [4:0] rt, input logic [1:0] tu_rt);
      bus.d_rs      = rs;
      bus.d_tuse_rs = tu_rs;
      bus.d_rt      = rt;
      bus.d_tuse_rt = tu_rt;
   endtask

   task automatic md(input logic is_div);
      bus.d_md_start  = 1'b1;
      bus.d_md_is_div = is_div;
      bus.d_md_use    = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic flush(input int n);
      idle_d();
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      n_vec  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      idle_d();
      #3;
      chk4("reset", 1'b0, 2'd0, 2'd0, 1'b0);
      #9 rst_n = 1'b1;
      tick();

      // lw $8 then add reading $8 at tuse=1
      wr(5'd8, 2'd3);
      settle(); chk4("t1_lw", 1'b0, 2'd0, 2'd0, 1'b0); tick();
      idle_d(); rd(5'd8, 2'd1, 5'd0, 2'd0);
      settle(); chk4("t1_c1", 1'b1, 2'd0, 2'd0, 1'b0); tick();
      settle(); chk4("t1_c2", 1'b0, 2'd0, 2'd0, 1'b0); tick();
      settle(); chk4("t1_c3", 1'b0, 2'd3, 2'd0, 1'b0); tick();
      flush(3);

      // ori $9 then beq $9,$9 at tuse=0: both operands stall then forward from M
      wr(5'd9, 2'd2); tick();
      idle_d(); rd(5'd9, 2'd0, 5'd9, 2'd0);
      settle(); chk4("t2_c1", 1'b1, 2'd0, 2'd0, 1'b0); tick();
      settle(); chk4("t2_c2", 1'b0, 2'd2, 2'd2, 1'b0); tick();
      flush(3);

      // add $10 in E shadows lw $10 in M
      wr(5'd10, 2'd3); tick();
      idle_d(); wr(5'd10, 2'd2); tick();
      idle_d(); rd(5'd10, 2'd1, 5'd0, 2'd0);
      settle(); chk4("t3_e", 1'b0, 2'd0, 2'd0, 1'b0); tick();
      settle(); chk4("t3_m", 1'b0, 2'd2, 2'd0, 1'b0); tick();
      flush(3);

      // writer to $0 never creates a hazard
      wr(5'd0, 2'd3); tick();
      idle_d(); rd(5'd0, 2'd0, 5'd0, 2'd0);
      settle(); chk4("t4_e", 1'b0, 2'd0, 2'd0, 1'b0); tick();
      settle(); chk4("t4_m", 1'b0, 2'd0, 2'd0, 1'b0); tick();
      flush(3);

      // div then mfhi: 10 stalled cycles
      md(1'b1);
      settle(); chk4("t5_div_acc", 1'b0, 2'd0, 2'd0, 1'b0); tick();
      idle_d(); bus.d_md_use = 1'b1; wr(5'd12, 2'd2);
      for (int i = 0; i < 10; i++) begin
         settle(); chk4($sformatf("t5_div%0d", i), 1'b1, 2'd0, 2'd0, 1'b1); tick();
      end
      settle(); chk4("t5_div_rel", 1'b0, 2'd0, 2'd0, 1'b0); tick();
      flush(3);

      // mult then mflo: 5 stalled cycles
      md(1'b0); tick();
      idle_d(); bus.d_md_use = 1'b1; wr(5'd13, 2'd2);
      for (int i = 0; i < 5; i++) begin
         settle(); chk4($sformatf("t5_mul%0d", i), 1'b1, 2'd0, 2'd0, 1'b1); tick();
      end
      settle(); chk4("t5_mul_rel", 1'b0, 2'd0, 2'd0, 1'b0); tick();
      flush(3);

      // mult held by a data stall must not load until accepted
      wr(5'd8, 2'd3); tick();
      idle_d(); rd(5'd8, 2'd1, 5'd0, 2'd0); md(1'b0);
      settle(); chk4("t5b_hold", 1'b1, 2'd0, 2'd0, 1'b0); tick();
      settle(); chk4("t5b_acc", 1'b0, 2'd0, 2'd0, 1'b0); tick();
      idle_d();
      settle(); chk4("t5b_busy", 1'b0, 2'd0, 2'd0, 1'b1); tick();
      flush(6);

      // async reset with md count 7 and lw $8 in E
      md(1'b1); tick();
      idle_d(); tick(); tick();
      wr(5'd8, 2'd3); tick();
      idle_d(); rd(5'd8, 2'd1, 5'd0, 2'd0);
      #1 chk4("t6_pre", 1'b1, 2'd0, 2'd0, 1'b1);
      rst_n = 1'b0;
      #1 chk4("t6_rst", 1'b0, 2'd0, 2'd0, 1'b0);
      #1 rst_n = 1'b1;
      settle(); chk4("t6_post", 1'b0, 2'd0, 2'd0, 1'b0); tick();
      settle(); chk4("t6_post2", 1'b0, 2'd0, 2'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
